// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: walks a registered index over [lo, hi] with ack handshake to feed the 6-to-64 decoder.
// Optional DECODER_SCAN_REVERSE_EN adds dir_i for descending scans.
module decoder_scan_seq #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          loop_i,
  input  logic [AW-1:0] lo_i,
  input  logic [AW-1:0] hi_i,
  input  logic          ack_i,
`ifdef DECODER_SCAN_REVERSE_EN
  input  logic          dir_i,
`endif
  output logic [AW-1:0] x_o,
  output logic          en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [AW-1:0] ONE = AW'(1);
  state_t state_q, state_d;
  logic [AW-1:0] x_q, x_d, lo_q, lo_d, hi_q, hi_d, first, last;
  logic loop_q, loop_d, dir_q, dir_d, done_q, done_d, err_q, err_d, dir_in;
`ifdef DECODER_SCAN_REVERSE_EN
  assign dir_in = dir_i;
`else
  assign dir_in = 1'b0;
`endif
  assign first = dir_q ? hi_q : lo_q;
  assign last  = dir_q ? lo_q : hi_q;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    loop_d  = loop_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start_i && lo_i > hi_i) begin
        err_d = 1'b1;
      end else if (start_i) begin
        state_d = RUN;
        lo_d    = lo_i;
        hi_d    = hi_i;
        loop_d  = loop_i;
        dir_d   = dir_in;
        x_d     = dir_in ? hi_i : lo_i;
      end
    end else if (ack_i) begin
      // The step out of the last index is always a reload or an exit, so x never wraps.
      if (x_q == last) begin
        done_d  = 1'b1;
        x_d     = loop_q ? first : x_q;
        state_d = loop_q ? RUN : IDLE;
      end else begin
        x_d = dir_q ? x_q - ONE : x_q + ONE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      loop_q  <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      loop_q  <= loop_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign x_o    = x_q;
  assign en_o   = state_q == RUN;
  assign busy_o = state_q == RUN;
  assign done_o = done_q;
  assign err_o  = err_q;
endmodule

// File: doc/decoder_scan_seq.md
# decoder_scan_seq

Registered index sequencer that drives the select input and enable of the 6-to-64 decoder stage. On a start request it walks a 6-bit index through a programmable inclusive range [lo, hi]. It holds each index with `en` asserted until the consumer acknowledges it, then advances. It is the upstream feeder for the one-hot decoder: `x` and `en` connect directly to the decoder's `x` and `en`.

## Interface
Parameters:
- `AW`, 6: index width; the decoder fan-out is 2^AW.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a scan; sampled only in IDLE.
- `stop`  in  1  abort the scan; has priority over every other event.
- `loop`  in  1  at `hi`, wrap to `lo` and continue; sampled with `start`.
- `lo`  in  AW  first index; sampled with `start`.
- `hi`  in  AW  last index; sampled with `start`.
- `ack`  in  1  consumer has taken the current index; meaningful only while `en`=1.
- `x`  out  AW  current index; drives decoder `x`.
- `en`  out  1  index valid; drives decoder `en`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when `hi` is acknowledged.
- `err`  out  1  one-cycle pulse when `start` is rejected because `lo`>`hi`.

## Operation
- States: IDLE and RUN. All outputs are registered.
- Reset state: IDLE, `x`=0, `en`=0, `busy`=0, `done`=0, `err`=0.
- IDLE with `start`=1 and `lo`<=`hi`:
  - Capture `lo`, `hi` and `loop`.
  - Go to RUN with `x`=`lo` and `en`=1.
- IDLE with `start`=1 and `lo`>`hi`: stay in IDLE and pulse `err`.
- RUN, `en`=1, `ack`=1, `x`!=`hi`: `x`<=`x`+1.
- RUN, `ack`=1, `x`==`hi`: pulse `done`.
  - If the captured `loop`=0: go to IDLE, `en`=0.
  - If the captured `loop`=1: `x`<=`lo` and stay in RUN.
- RUN, `ack`=0: `x` and `en` hold, with no time limit.
- `stop`=1 in any state: next cycle is IDLE with `en`=0 and `done`=0, and `x` holds its last value. This also applies when `stop` and `ack` are asserted in the same cycle; the acknowledged index does not count as completed.
- `start` in RUN is ignored, as is any change to `lo`, `hi` or `loop`.
- `lo`==`hi`: a single index is scanned; `done` pulses on its `ack`.
- Full range `lo`=0, `hi`=2^AW-1: `x` never overflows, because the step from `hi` is always a reload or an exit, never an increment.
- Asserting `rst_n` during RUN forces the reset state immediately, without waiting for a clock edge.

## Timing
- Start latency: `start` is sampled at edge N; `en`=1 and `x`=`lo` are visible after edge N (cycle N+1).
- Throughput: with `ack` held at 1, one index per cycle, so the range takes hi-lo+1 cycles.
- Completion: `done` is high for the single cycle that follows the edge at which `hi` is acknowledged.
  - Non-loop mode: `en` and `busy` fall in that same cycle.
  - Loop mode: `x`=`lo` in that same cycle.
- Restart: a new `start` is accepted on the cycle after IDLE is re-entered. There are no back-to-back restarts without one IDLE cycle.
- `err` pulses in the cycle after the rejected `start`.
- `stop`: `en` is low in the cycle after `stop` is sampled.

## Configuration
- `DECODER_SCAN_REVERSE_EN` defined:
  - Adds input `dir` (1 bit), sampled with `start`.
  - `dir`=1 scans from `hi` down to `lo`: start value `hi`, step -1, `done` on acknowledgement of `lo`, loop reload to `hi`.
  - `dir`=0 behaves exactly as the macro-undefined build.
- Macro undefined: no `dir` port; scans are ascending only.

## Test plan
- Reset then `start` with `lo`=3, `hi`=6, `loop`=0, `ack`=1 held:
  - Required: `x`=3,4,5,6 on four consecutive cycles with `en`=1.
  - Required: `done` pulses once, then `en`=0 and `busy`=0.
- `lo`=0, `hi`=63, `loop`=1, with `ack` toggling every other cycle:
  - Required: each index is held for 2 cycles.
  - Required: after 63, `x`=0 with `done` pulsed, and no gap in `en`.
- `start` with `lo`=10, `hi`=5: `err` pulses once, `busy` stays 0, `en` stays 0.
- Mid-scan at `x`=20, assert `stop` and `ack` together: next cycle `en`=0, `x`=20, `done`=0.
- Pull `rst_n` low asynchronously mid-scan: outputs read 0 before the next clock edge.
- With `DECODER_SCAN_REVERSE_EN` defined, `dir`=1, `lo`=2, `hi`=4: `x`=4,3,2, then `done`.
